fetch_sequencer: RTL and testbench

Instruction-fetch controller that sits between the instruction memory port and the instruction decoder. It generates fetch addresses, runs a single-outstanding request/grant/response handshake, and buffers one fetched word. It presents that word to the decoder together with the decoder's `busy` hold signal, and handles pipeline redirects (branch/jump) by flushing the buffer and discarding any stale in-flight response.

---
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch controller.
// Issues fetch addresses, tracks one in-flight request and buffers one word
// for the decoder. Redirects flush the buffer and kill a stale response.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_req,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic        buf_valid;
    logic        kill;

    logic        consume;
    logic        hold;
    logic        grant;
    logic        outstanding;

    // A held (stalled) word blocks new requests so a response can never
    // land on top of a word the decoder has not taken yet.
    assign consume     = buf_valid && !stall_req;
    assign hold        = buf_valid && stall_req;
    assign imem_req    = (state == REQ) && !hold;
    assign grant       = imem_req && imem_gnt;
    assign imem_addr   = pc;

    // A request is still owed a response after this edge: granted now, or
    // waiting and the data has not shown up this cycle.
    assign outstanding = grant || ((state == WAIT) && !imem_rvalid);

    // Decoder-facing view of the buffer; busy is a straight pass-through.
    assign instruction = buf_valid ? buf_inst : NOP_INST;
    assign inst_valid  = buf_valid;
    assign inst_pc     = buf_pc;
    assign busy        = stall_req;

    // FSM, fetch pointer, buffer and kill flag; redirect is applied last so
    // it overrides consume, response and grant effects on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            buf_inst  <= NOP_INST;
            buf_pc    <= RESET_PC;
            buf_valid <= 1'b0;
            kill      <= 1'b0;
        end else begin
            if (consume) begin
                buf_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (grant) begin
                        req_addr <= pc;
                        pc       <= pc + 32'd4;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        kill  <= 1'b0;
                        state <= REQ;
                        if (!kill && !redirect_valid) begin
                            buf_inst  <= imem_rdata;
                            buf_pc    <= req_addr;
                            buf_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (redirect_valid) begin
                buf_valid <= 1'b0;
                pc        <= redirect_pc & 32'hFFFF_FFFC;
                if (outstanding) begin
                    kill  <= 1'b1;
                    state <= WAIT;
                end else begin
                    kill  <= 1'b0;
                    state <= REQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed test-plan steps followed by a random
// phase, all checked every cycle against a transaction-level reference.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt       = 1'b0;
    logic        imem_rvalid    = 1'b0;
    logic [31:0] imem_rdata     = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        stall_req      = 1'b0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        busy;

    fetch_sequencer #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_req      (stall_req),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference: has fetching started, is a response owed, is it stale,
    // and what word (if any) the decoder is currently being shown
    bit          started;
    bit          owed;
    bit          stale;
    bit          shown;
    logic [31:0] next_fetch;
    logic [31:0] owed_addr;
    logic [31:0] shown_inst;
    logic [31:0] shown_pc;

    // memory responder: one pending reply, due on a given cycle
    bit          mem_pend  = 1'b0;
    int          mem_due   = 0;
    logic [31:0] mem_word  = 32'h0;
    int          mem_lat   = 1;
    bit          mem_rand  = 1'b0;
    logic [31:0] mem_fixed = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: assert reset, check reset values, release.
    task automatic do_reset();
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        stall_req      = 1'b0;
        #1;
        chk("rst_imem_req",    32'(imem_req),   32'd0);
        chk("rst_imem_addr",   imem_addr,       RESET_PC);
        chk("rst_instruction", instruction,     NOP);
        chk("rst_inst_pc",     inst_pc,         RESET_PC);
        chk("rst_inst_valid",  32'(inst_valid), 32'd0);
        stall_req = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd1);
        stall_req = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        started    = 1'b0;
        owed       = 1'b0;
        stale      = 1'b0;
        shown      = 1'b0;
        next_fetch = RESET_PC;
        owed_addr  = RESET_PC;
        shown_inst = NOP;
        shown_pc   = RESET_PC;
    endtask

    // One clock: drive inputs at the falling edge, check, advance reference.
    task automatic cycle(input bit stall, input bit redir, input logic [31:0] rpc, input bit gnt);
        bit          rv;
        bit          exp_req;
        bit          granted;
        logic [31:0] rd;
        rv = mem_pend && (mem_due == cyc);
        rd = rv ? mem_word : 32'hBAD0_BAD0;
        stall_req      = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_gnt       = gnt;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        #1;
        exp_req = started && !owed && !(shown && stall);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, next_fetch);
        chk("inst_valid",  32'(inst_valid), 32'(shown));
        chk("instruction", instruction, shown ? shown_inst : NOP);
        chk("inst_pc",     inst_pc, shown_pc);
        chk("busy",        32'(busy), 32'(stall));

        granted = exp_req && gnt;
        if (rv) mem_pend = 1'b0;
        if (granted) begin
            mem_pend = 1'b1;
            mem_due  = cyc + mem_lat;
            mem_word = mem_rand ? $urandom : mem_fixed;
        end

        if (redir) begin
            shown = 1'b0;
            if (rv && owed) begin
                owed  = 1'b0;
                stale = 1'b0;
            end else if (owed || granted) begin
                owed  = 1'b1;
                stale = 1'b1;
            end
            next_fetch = {rpc[31:2], 2'b00};
        end else begin
            if (shown && !stall) shown = 1'b0;
            if (rv && owed) begin
                owed = 1'b0;
                if (stale) stale = 1'b0;
                else begin
                    shown      = 1'b1;
                    shown_inst = rd;
                    shown_pc   = owed_addr;
                end
            end
            if (granted) begin
                owed       = 1'b1;
                owed_addr  = next_fetch;
                next_fetch = next_fetch + 32'd4;
            end
        end
        started = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // first fetch with zero-wait memory
        mem_lat   = 1;
        mem_fixed = 32'h0050_0093;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_first_req",  32'(imem_req), 32'd1);
        chk("tp_first_addr", imem_addr, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("tp_first_inst",  instruction, 32'h0050_0093);
        chk("tp_first_pc",    inst_pc, 32'h0);
        chk("tp_first_valid", 32'(inst_valid), 32'd1);
        chk("tp_next_addr",   imem_addr, 32'h4);

        // stall with a buffered word, then resume
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            chk("tp_stall_inst", instruction, 32'h0050_0093);
        end
        mem_fixed = 32'h00A0_0113;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_resume_pc", inst_pc, 32'h4);

        // grant backpressure at address 8
        mem_fixed = 32'h0020_8193;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            chk("tp_bp_req",  32'(imem_req), 32'd1);
            chk("tp_bp_addr", imem_addr, 32'h8);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        // redirect while the fetch of 12 is in flight
        mem_lat   = 3;
        mem_fixed = 32'hDEAD_0001;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_redir_addr",  imem_addr, 32'h100);
        chk("tp_redir_valid", 32'(inst_valid), 32'd0);
        mem_lat   = 1;
        mem_fixed = 32'h0000_0513;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_redir_pc",   inst_pc, 32'h100);
        chk("tp_redir_inst", instruction, 32'h0000_0513);

        // redirect while stalled on a buffered word
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        chk("tp_flush_valid", 32'(inst_valid), 32'd0);
        chk("tp_flush_inst",  instruction, NOP);

        // wrap-around of the fetch pointer
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("tp_wrap_addr", imem_addr, 32'h0);
        mem_fixed = 32'h0000_0613;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_wrap_pc", inst_pc, 32'hFFFF_FFFC);

        // redirect coinciding with a response
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0300, 1'b0);
        chk("tp_same_addr",  imem_addr, 32'h300);
        chk("tp_same_valid", 32'(inst_valid), 32'd0);
        mem_fixed = 32'h0000_0713;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_same_pc", inst_pc, 32'h300);

        // reset with a response in flight; it lands after reset
        mem_lat = 2;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("tp_mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("tp_mid_rst_addr",  imem_addr, RESET_PC);

        // random phase
        mem_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            mem_lat = $urandom_range(1, 3);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
